// File: rtl/traffic_signal_monitor_pkg.sv
// Shared lamp codes, phase encodings and violation codes for the traffic signal monitor,
// plus helpers that map lamp patterns to phases and give the legal successor phase.
package traffic_signal_monitor_pkg;

    localparam logic [1:0] LAMP_RED    = 2'd0;
    localparam logic [1:0] LAMP_YELLOW = 2'd1;
    localparam logic [1:0] LAMP_GREEN  = 2'd2;
    localparam logic [1:0] LAMP_BAD    = 2'd3;

    typedef enum logic [2:0] {
        PH_HG_CR = 3'd0,
        PH_HY_CR = 3'd1,
        PH_HR_CR = 3'd2,
        PH_HR_CG = 3'd3,
        PH_HR_CY = 3'd4,
        PH_UNK   = 3'd7
    } phase_t;

    typedef enum logic [2:0] {
        VC_NONE         = 3'd0,
        VC_ILLEGAL_CODE = 3'd1,
        VC_CONFLICT     = 3'd2,
        VC_BAD_SEQ      = 3'd3,
        VC_SHORT_YELLOW = 3'd4,
        VC_SHORT_ALLRED = 3'd5,
        VC_NO_DEMAND    = 3'd6
    } viol_code_t;

    function automatic phase_t next_phase(input phase_t p);
        phase_t n;
        case (p)
            PH_HG_CR: n = PH_HY_CR;
            PH_HY_CR: n = PH_HR_CR;
            PH_HR_CR: n = PH_HR_CG;
            PH_HR_CG: n = PH_HR_CY;
            PH_HR_CY: n = PH_HG_CR;
            default:  n = PH_UNK;
        endcase
        return n;
    endfunction

    // Patterns that are not one of the five legal phases decode to PH_UNK.
    function automatic phase_t decode_lamps(input logic [1:0] h, input logic [1:0] c);
        phase_t p;
        case ({h, c})
            {LAMP_GREEN,  LAMP_RED}:    p = PH_HG_CR;
            {LAMP_YELLOW, LAMP_RED}:    p = PH_HY_CR;
            {LAMP_RED,    LAMP_RED}:    p = PH_HR_CR;
            {LAMP_RED,    LAMP_GREEN}:  p = PH_HR_CG;
            {LAMP_RED,    LAMP_YELLOW}: p = PH_HR_CY;
            default:                    p = PH_UNK;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/traffic_signal_monitor_dwell_counter.sv
// Saturating dwell counter: clr alone -> 0, clr with inc -> 1 (first cycle of a new phase),
// inc alone -> count+1, holding at all-ones.
module tl_dwell_counter #(
    parameter int DW_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clr,
    input  logic            inc,
    output logic [DW_W-1:0] count
);

    logic [DW_W-1:0] count_q;
    logic [DW_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = inc ? DW_W'(1) : '0;
        end else if (inc && (count_q != {DW_W{1'b1}})) begin
            count_d = count_q + DW_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/traffic_signal_monitor.sv
// Passive checker for the traffic light controller's lamp outputs: tracks the phase sequence,
// enforces minimum yellow/all-red dwell, flags violations and counts completed signal cycles.
module traffic_signal_monitor
    import traffic_signal_monitor_pkg::*;
#(
    parameter int Y2R_MIN = 3,
    parameter int R2G_MIN = 2,
    parameter int DW_W    = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       hwy,
    input  logic [1:0]       cntry,
    input  logic             x,
    output logic [2:0]       phase,
    output logic             viol,
    output logic [2:0]       viol_code,
    output logic             err,
    output logic [2:0]       err_code,
    output logic [CNT_W-1:0] cyc_cnt
);

    localparam logic [DW_W-1:0] Y2R_MIN_W = DW_W'(Y2R_MIN);
    localparam logic [DW_W-1:0] R2G_MIN_W = DW_W'(R2G_MIN);

    phase_t            phase_q, phase_d;
    logic              viol_q, viol_d;
    viol_code_t        viol_code_q, viol_code_d;
    logic              err_q, err_d;
    viol_code_t        err_code_q, err_code_d;
    logic [CNT_W-1:0]  cyc_cnt_q, cyc_cnt_d;
    logic              x_q, x_d;

    phase_t            obs_phase;
    logic              dw_clr;
    logic              dw_inc;
    logic [DW_W-1:0]   dwell;

    tl_dwell_counter #(
        .DW_W (DW_W)
    ) u_dwell (
        .clk   (clk),
        .reset (reset),
        .clr   (dw_clr),
        .inc   (dw_inc),
        .count (dwell)
    );

    always_comb begin
        obs_phase   = decode_lamps(hwy, cntry);
        phase_d     = phase_q;
        viol_code_d = VC_NONE;
        dw_clr      = 1'b0;
        dw_inc      = 1'b0;
        cyc_cnt_d   = cyc_cnt_q;
        err_d       = err_q;
        err_code_d  = err_code_q;
        x_d         = x;

        if ((hwy == LAMP_BAD) || (cntry == LAMP_BAD)) begin
            viol_code_d = VC_ILLEGAL_CODE;
            phase_d     = PH_UNK;
            dw_clr      = 1'b1;
        end else if ((hwy != LAMP_RED) && (cntry != LAMP_RED)) begin
            viol_code_d = VC_CONFLICT;
            phase_d     = PH_UNK;
            dw_clr      = 1'b1;
        end else if (phase_q == PH_UNK) begin
            // Silent resync: no sequence or dwell check, and no cycle credit.
            phase_d = obs_phase;
            dw_clr  = 1'b1;
            dw_inc  = 1'b1;
        end else if (obs_phase == phase_q) begin
            dw_inc = 1'b1;
        end else begin
            // Always follow the observed phase so one fault does not cascade.
            phase_d = obs_phase;
            dw_clr  = 1'b1;
            dw_inc  = 1'b1;
            if (obs_phase != next_phase(phase_q)) begin
                viol_code_d = VC_BAD_SEQ;
            end else begin
                case (phase_q)
                    PH_HY_CR, PH_HR_CY: begin
                        if (dwell < Y2R_MIN_W) viol_code_d = VC_SHORT_YELLOW;
                    end
                    PH_HR_CR: begin
                        if (dwell < R2G_MIN_W) viol_code_d = VC_SHORT_ALLRED;
                    end
                    PH_HG_CR: begin
                        if (!x_q) viol_code_d = VC_NO_DEMAND;
                    end
                    default: ;
                endcase
                if (phase_q == PH_HR_CY) begin
                    cyc_cnt_d = cyc_cnt_q + CNT_W'(1);
                end
            end
        end

        viol_d = (viol_code_d != VC_NONE);
        if (viol_d && !err_q) begin
            err_d      = 1'b1;
            err_code_d = viol_code_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q     <= PH_HG_CR;
            viol_q      <= 1'b0;
            viol_code_q <= VC_NONE;
            err_q       <= 1'b0;
            err_code_q  <= VC_NONE;
            cyc_cnt_q   <= '0;
            x_q         <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            viol_q      <= viol_d;
            viol_code_q <= viol_code_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            cyc_cnt_q   <= cyc_cnt_d;
            x_q         <= x_d;
        end
    end

    assign phase     = phase_q;
    assign viol      = viol_q;
    assign viol_code = viol_code_q;
    assign err       = err_q;
    assign err_code  = err_code_q;
    assign cyc_cnt   = cyc_cnt_q;

endmodule

// File: tb/tb_traffic_signal_monitor.sv
// Self-checking bench for traffic_signal_monitor: directed scenarios plus a randomized run
// compared against a rule-level reference model.
module tb_traffic_signal_monitor;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  hwy = 2'd2;
    logic [1:0]  cntry = 2'd0;
    logic        x = 1'b0;
    logic [2:0]  phase;
    logic        viol;
    logic [2:0]  viol_code;
    logic        err;
    logic [2:0]  err_code;
    logic [15:0] cyc_cnt;

    int checks = 0;
    int failures = 0;
    int txn = 0;

    traffic_signal_monitor dut (
        .clk       (clk),
        .reset     (reset),
        .hwy       (hwy),
        .cntry     (cntry),
        .x         (x),
        .phase     (phase),
        .viol      (viol),
        .viol_code (viol_code),
        .err       (err),
        .err_code  (err_code),
        .cyc_cnt   (cyc_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: phase index 0..4 in legal order, 7 = unknown.
    int pat_h [5] = '{2, 1, 0, 0, 0};
    int pat_c [5] = '{0, 0, 0, 2, 1};
    int m_phase, m_dwell, m_code, m_err, m_err_code, m_cyc, m_xq;

    function automatic int pattern_of(input int h, input int c);
        for (int i = 0; i < 5; i++) begin
            if (pat_h[i] == h && pat_c[i] == c) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_dwell = 0; m_code = 0;
        m_err = 0; m_err_code = 0; m_cyc = 0; m_xq = 0;
    endtask

    task automatic model_step(input int h, input int c, input int xv);
        int obs;
        m_code = 0;
        if (h == 3 || c == 3) begin
            m_code = 1; m_phase = 7; m_dwell = 0;
        end else if (h != 0 && c != 0) begin
            m_code = 2; m_phase = 7; m_dwell = 0;
        end else begin
            obs = pattern_of(h, c);
            if (m_phase == 7) begin
                m_phase = obs; m_dwell = 1;
            end else if (obs == m_phase) begin
                m_dwell = (m_dwell >= 15) ? 15 : m_dwell + 1;
            end else begin
                if (obs != (m_phase + 1) % 5) m_code = 3;
                else if ((m_phase == 1 || m_phase == 4) && m_dwell < 3) m_code = 4;
                else if (m_phase == 2 && m_dwell < 2) m_code = 5;
                else if (m_phase == 0 && m_xq == 0) m_code = 6;
                if (m_phase == 4 && obs == 0) m_cyc = (m_cyc + 1) % 65536;
                m_phase = obs; m_dwell = 1;
            end
        end
        if (m_code != 0 && m_err == 0) begin
            m_err = 1; m_err_code = m_code;
        end
        m_xq = xv;
    endtask

    task automatic step(input int h, input int c, input int xv);
        hwy = 2'(h); cntry = 2'(c); x = 1'(xv);
        @(posedge clk);
        model_step(h, c, xv);
        #1;
        txn++;
        $display("txn %0d hwy=%0d cntry=%0d x=%0d -> phase=%0d viol=%0d code=%0d err=%0d err_code=%0d cyc=%0d",
                 txn, h, c, xv, phase, viol, viol_code, err, err_code, cyc_cnt);
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        hwy = 2'd2; cntry = 2'd0; x = 1'b0;
        reset = 1'b1;
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        #2;
        if (phase !== 3'd0 || viol !== 1'b0 || viol_code !== 3'd0 || err !== 1'b0 ||
            err_code !== 3'd0 || cyc_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_state: phase=%0d viol=%0d code=%0d err=%0d err_code=%0d cyc=%0d, required all 0",
                     phase, viol, viol_code, err, err_code, cyc_cnt);
        end
        checks++;
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_legal_cycle();
        int saw_viol = 0;
        apply_reset();
        repeat (5) begin step(2, 0, 1); saw_viol |= int'(viol); end
        repeat (3) begin step(1, 0, 1); saw_viol |= int'(viol); end
        repeat (2) begin step(0, 0, 1); saw_viol |= int'(viol); end
        repeat (4) begin step(0, 2, 1); saw_viol |= int'(viol); end
        repeat (3) begin step(0, 1, 1); saw_viol |= int'(viol); end
        step(2, 0, 1); saw_viol |= int'(viol);
        checks++;
        if (saw_viol != 0) begin failures++; $display("FAIL legal_no_viol: viol seen=%0d required 0", saw_viol); end
        checks++;
        if (cyc_cnt !== 16'd1) begin failures++; $display("FAIL legal_cyc_cnt: got %0d required 1", cyc_cnt); end
        checks++;
        if (err !== 1'b0 || phase !== 3'd0) begin
            failures++; $display("FAIL legal_err_phase: err=%0d phase=%0d required err=0 phase=0", err, phase);
        end
    endtask

    task automatic test_short_yellow();
        apply_reset();
        repeat (2) step(2, 0, 1);
        repeat (2) step(1, 0, 1);
        step(0, 0, 1);
        checks++;
        if (viol !== 1'b1 || viol_code !== 3'd4 || err_code !== 3'd4 || phase !== 3'd2) begin
            failures++;
            $display("FAIL short_yellow: viol=%0d code=%0d err_code=%0d phase=%0d required 1/4/4/2",
                     viol, viol_code, err_code, phase);
        end
        step(0, 0, 1);
        checks++;
        if (viol !== 1'b0 || viol_code !== 3'd0 || err !== 1'b1) begin
            failures++;
            $display("FAIL short_yellow_pulse: viol=%0d code=%0d err=%0d required 0/0/1", viol, viol_code, err);
        end
    endtask

    task automatic test_conflict();
        logic [15:0] cyc_before;
        apply_reset();
        repeat (3) step(2, 0, 1);
        cyc_before = cyc_cnt;
        step(2, 2, 1);
        checks++;
        if (viol !== 1'b1 || viol_code !== 3'd2 || phase !== 3'd7) begin
            failures++;
            $display("FAIL conflict: viol=%0d code=%0d phase=%0d required 1/2/7", viol, viol_code, phase);
        end
        step(2, 0, 1);
        checks++;
        if (phase !== 3'd0 || viol !== 1'b0 || cyc_cnt !== cyc_before) begin
            failures++;
            $display("FAIL conflict_resync: phase=%0d viol=%0d cyc=%0d required 0/0/%0d",
                     phase, viol, cyc_cnt, cyc_before);
        end
    endtask

    task automatic test_no_demand_priority();
        apply_reset();
        repeat (3) step(2, 0, 0);
        step(1, 0, 0);
        checks++;
        if (viol !== 1'b1 || viol_code !== 3'd6 || err_code !== 3'd6) begin
            failures++;
            $display("FAIL no_demand: viol=%0d code=%0d err_code=%0d required 1/6/6", viol, viol_code, err_code);
        end
        repeat (3) step(1, 0, 0);
        step(3, 2, 0);
        checks++;
        if (viol_code !== 3'd1 || err_code !== 3'd6 || phase !== 3'd7) begin
            failures++;
            $display("FAIL illegal_priority: code=%0d err_code=%0d phase=%0d required 1/6/7",
                     viol_code, err_code, phase);
        end
    endtask

    task automatic test_skip_phase();
        logic [15:0] cyc_before;
        int saw_viol = 0;
        apply_reset();
        repeat (3) step(2, 0, 1);
        cyc_before = cyc_cnt;
        step(0, 2, 1);
        checks++;
        if (viol_code !== 3'd3 || phase !== 3'd3) begin
            failures++; $display("FAIL skip_bad_seq: code=%0d phase=%0d required 3/3", viol_code, phase);
        end
        repeat (3) begin step(0, 1, 1); saw_viol |= int'(viol); end
        step(2, 0, 1); saw_viol |= int'(viol);
        checks++;
        if (cyc_cnt !== cyc_before + 16'd1 || saw_viol != 0) begin
            failures++;
            $display("FAIL skip_resume: cyc=%0d viol_seen=%0d required %0d/0", cyc_cnt, saw_viol, cyc_before + 16'd1);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        repeat (2) step(2, 0, 1);
        step(0, 2, 1);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        checks++;
        if (phase !== 3'd0 || viol !== 1'b0 || viol_code !== 3'd0 || err !== 1'b0 ||
            err_code !== 3'd0 || cyc_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_mid: phase=%0d viol=%0d code=%0d err=%0d err_code=%0d cyc=%0d required all 0",
                     phase, viol, viol_code, err, err_code, cyc_cnt);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        step(0, 0, 1);
        checks++;
        if (viol_code !== 3'd3 || phase !== 3'd2 || err_code !== 3'd3) begin
            failures++;
            $display("FAIL post_reset_bad_seq: code=%0d phase=%0d err_code=%0d required 3/2/3",
                     viol_code, phase, err_code);
        end
    endtask

    task automatic test_random();
        int gp = 0;
        int h, c, xv, r;
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            r = int'($urandom_range(99));
            if (r < 60) begin
                h = pat_h[gp]; c = pat_c[gp];
            end else if (r < 88) begin
                gp = (gp + 1) % 5; h = pat_h[gp]; c = pat_c[gp];
            end else if (r < 95) begin
                gp = int'($urandom_range(4)); h = pat_h[gp]; c = pat_c[gp];
            end else begin
                h = int'($urandom_range(3)); c = int'($urandom_range(3));
            end
            xv = ($urandom_range(9) < 8) ? 1 : 0;
            step(h, c, xv);
            checks++;
            if (phase !== 3'(m_phase) || viol !== 1'(m_code != 0) || viol_code !== 3'(m_code) ||
                err !== 1'(m_err) || err_code !== 3'(m_err_code) || cyc_cnt !== 16'(m_cyc)) begin
                failures++;
                $display("FAIL random_%0d: got phase=%0d viol=%0d code=%0d err=%0d err_code=%0d cyc=%0d required %0d/%0d/%0d/%0d/%0d/%0d",
                         n, phase, viol, viol_code, err, err_code, cyc_cnt,
                         m_phase, (m_code != 0), m_code, m_err, m_err_code, m_cyc);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_legal_cycle();
        test_short_yellow();
        test_conflict();
        test_no_demand_priority();
        test_skip_phase();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
